// File: rtl/operand_load_pkg.sv
// Shared types and default sizing for the operand load scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package operand_load_pkg;

    localparam int DEF_DATA_WIDTH         = 16;
    localparam int DEF_LOG2_OF_MEM_HEIGHT = 20;
    localparam int DEF_B_WORDS            = 36864;
    localparam int DEF_A_WORDS            = 4096;
    localparam int DEF_NB_TILES           = 2;
    localparam int CNT_WIDTH              = 32;
    localparam int TILE_IDX_WIDTH         = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_B    = 3'd1,
        ST_LOAD_A    = 3'd2,
        ST_READY     = 3'd3,
        ST_WAIT_DONE = 3'd4
    } load_state_t;

endpackage

// File: rtl/operand_load_scheduler_load_counter.sv
// Word counter for one operand stream: counts accepted words, wraps at LIMIT.
// Latency: count and last flag update on the edge after i_en.
// Backpressure: none; advances only when the caller's handshake fires.
module load_counter
    import operand_load_pkg::*;
#(
    parameter int LIMIT  = 4,
    parameter int ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LIMIT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_cnt;

    assign o_last = (r_cnt == CNT_LAST);
    assign o_addr = r_cnt[ADDR_W-1:0];

    // Count accepted words; the last word of a block returns the count to 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_last ? '0 : (r_cnt + CNT_ONE);
        end
    end

endmodule

// File: rtl/operand_load_scheduler.sv
// Streams one job's weights once, then each tile's activations, into operand memories.
// Latency: memory write in the handshake cycle; data_ready one cycle after the last a-word.
// Backpressure: ready depends only on state; a word is written only when valid and ready meet.
module operand_load_scheduler
    import operand_load_pkg::*;
#(
    parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int LOG2_OF_MEM_HEIGHT = DEF_LOG2_OF_MEM_HEIGHT,
    parameter int B_WORDS            = DEF_B_WORDS,
    parameter int A_WORDS            = DEF_A_WORDS,
    parameter int NB_TILES           = DEF_NB_TILES
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          start,
    output logic                          busy,
    input  logic [DATA_WIDTH-1:0]         b_input,
    input  logic                          b_valid,
    output logic                          b_ready,
    input  logic [DATA_WIDTH-1:0]         a_input,
    input  logic                          a_valid,
    output logic                          a_ready,
    output logic                          b_mem_we,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] b_mem_addr,
    output logic [DATA_WIDTH-1:0]         b_mem_wdata,
    output logic                          a_mem_we,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] a_mem_addr,
    output logic [DATA_WIDTH-1:0]         a_mem_wdata,
    output logic                          data_ready,
    input  logic                          tile_done,
    output logic [TILE_IDX_WIDTH-1:0]     tile_idx,
    output logic                          all_done
);

    // Reject sizes the memories or the 8-bit tile index cannot hold.
    if (longint'(A_WORDS) > (longint'(1) << LOG2_OF_MEM_HEIGHT)) begin : g_bad_a_words
        $error("A_WORDS exceeds operand memory height");
    end
    if (longint'(B_WORDS) > (longint'(1) << LOG2_OF_MEM_HEIGHT)) begin : g_bad_b_words
        $error("B_WORDS exceeds operand memory height");
    end
    if (NB_TILES < 1 || NB_TILES > 256) begin : g_bad_nb_tiles
        $error("NB_TILES must be in 1..256");
    end

    localparam logic [TILE_IDX_WIDTH-1:0] LAST_TILE = TILE_IDX_WIDTH'(NB_TILES - 1);
    localparam logic [TILE_IDX_WIDTH-1:0] TILE_ONE  = TILE_IDX_WIDTH'(1);

    load_state_t                  r_state;
    logic [TILE_IDX_WIDTH-1:0]    r_tile_idx;

    logic                          w_b_hs;
    logic                          w_a_hs;
    logic                          w_b_last;
    logic                          w_a_last;
    logic                          w_cnt_clr;
    logic                          w_last_tile;
    logic [LOG2_OF_MEM_HEIGHT-1:0] w_b_addr;
    logic [LOG2_OF_MEM_HEIGHT-1:0] w_a_addr;

    // Everything is forced quiet while reset is held, so a reset that lands
    // mid-load cannot produce one more write before the state clears.
    assign busy       = arst_n_in && (r_state != ST_IDLE);
    assign b_ready    = arst_n_in && (r_state == ST_LOAD_B);
    assign a_ready    = arst_n_in && (r_state == ST_LOAD_A);
    assign data_ready = arst_n_in && (r_state == ST_READY);
    assign tile_idx   = arst_n_in ? r_tile_idx : '0;

    assign w_b_hs      = b_valid && b_ready;
    assign w_a_hs      = a_valid && a_ready;
    assign w_last_tile = (r_tile_idx == LAST_TILE);
    assign all_done    = arst_n_in && (r_state == ST_WAIT_DONE) && tile_done && w_last_tile;

    // Address and data are zeroed outside write cycles to keep the ports idle-clean.
    assign b_mem_we    = w_b_hs;
    assign b_mem_addr  = w_b_hs ? w_b_addr : '0;
    assign b_mem_wdata = w_b_hs ? b_input  : '0;
    assign a_mem_we    = w_a_hs;
    assign a_mem_addr  = w_a_hs ? w_a_addr : '0;
    assign a_mem_wdata = w_a_hs ? a_input  : '0;

    assign w_cnt_clr = (r_state == ST_IDLE);

    load_counter #(
        .LIMIT  (B_WORDS),
        .ADDR_W (LOG2_OF_MEM_HEIGHT)
    ) u_b_cnt (
        .i_clk   (clk),
        .i_rst_n (arst_n_in),
        .i_clr   (w_cnt_clr),
        .i_en    (w_b_hs),
        .o_addr  (w_b_addr),
        .o_last  (w_b_last)
    );

    load_counter #(
        .LIMIT  (A_WORDS),
        .ADDR_W (LOG2_OF_MEM_HEIGHT)
    ) u_a_cnt (
        .i_clk   (clk),
        .i_rst_n (arst_n_in),
        .i_clr   (w_cnt_clr),
        .i_en    (w_a_hs),
        .o_addr  (w_a_addr),
        .o_last  (w_a_last)
    );

    // Job sequencing: weights once per job, then activations and a compute wait per tile.
    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            r_state    <= ST_IDLE;
            r_tile_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tile_idx <= '0;
                    if (start) begin
                        r_state <= ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (w_b_hs && w_b_last) begin
                        r_state <= ST_LOAD_A;
                    end
                end
                ST_LOAD_A: begin
                    if (w_a_hs && w_a_last) begin
                        r_state <= ST_READY;
                    end
                end
                ST_READY: begin
                    r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tile_done) begin
                        if (w_last_tile) begin
                            r_state    <= ST_IDLE;
                            r_tile_idx <= '0;
                        end else begin
                            r_state    <= ST_LOAD_A;
                            r_tile_idx <= r_tile_idx + TILE_ONE;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_tile_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_load_scheduler.sv
module tb_operand_load_scheduler;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          arst_n_in;
    logic          start;
    logic          busy;
    logic [DW-1:0] b_input;
    logic          b_valid;
    logic          b_ready;
    logic [DW-1:0] a_input;
    logic          a_valid;
    logic          a_ready;
    logic          b_mem_we;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_mem_wdata;
    logic          a_mem_we;
    logic [AW-1:0] a_mem_addr;
    logic [DW-1:0] a_mem_wdata;
    logic          data_ready;
    logic          tile_done;
    logic [7:0]    tile_idx;
    logic          all_done;

    int total = 0;
    int bad   = 0;

    operand_load_scheduler #(
        .DATA_WIDTH         (DW),
        .LOG2_OF_MEM_HEIGHT (AW),
        .B_WORDS            (3),
        .A_WORDS            (4),
        .NB_TILES           (2)
    ) dut (
        .clk         (clk),
        .arst_n_in   (arst_n_in),
        .start       (start),
        .busy        (busy),
        .b_input     (b_input),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .a_input     (a_input),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .b_mem_we    (b_mem_we),
        .b_mem_addr  (b_mem_addr),
        .b_mem_wdata (b_mem_wdata),
        .a_mem_we    (a_mem_we),
        .a_mem_addr  (a_mem_addr),
        .a_mem_wdata (a_mem_wdata),
        .data_ready  (data_ready),
        .tile_done   (tile_done),
        .tile_idx    (tile_idx),
        .all_done    (all_done)
    );

    always #5 clk = ~clk;

    // busy,b_ready,a_ready,b_we,b_addr,b_wdata,a_we,a_addr,a_wdata,data_ready,tile_idx,all_done
    typedef logic [54:0] out_t;

    out_t w_out;
    assign w_out = {busy, b_ready, a_ready, b_mem_we, b_mem_addr, b_mem_wdata,
                    a_mem_we, a_mem_addr, a_mem_wdata, data_ready, tile_idx, all_done};

    typedef struct {
        string         name;
        logic          rst_n;
        logic          st;
        logic          bv;
        logic [DW-1:0] bi;
        logic          av;
        logic [DW-1:0] ai;
        logic          td;
        out_t          exp;
    } vec_t;

    vec_t vq[$];

    function automatic out_t expo(logic bz, logic br, logic ar, logic bwe, logic [3:0] ba,
                                  logic [15:0] bd, logic awe, logic [3:0] aa, logic [15:0] ad,
                                  logic dr, logic [7:0] ti, logic alld);
        return {bz, br, ar, bwe, ba, bd, awe, aa, ad, dr, ti, alld};
    endfunction

    function automatic out_t e_lb(logic [3:0] a, logic [15:0] d);
        return expo(1, 1, 0, 1, a, d, 0, 0, 0, 0, 0, 0);
    endfunction
    function automatic out_t e_la(logic [3:0] a, logic [15:0] d, logic [7:0] t);
        return expo(1, 0, 1, 0, 0, 0, 1, a, d, 0, t, 0);
    endfunction
    function automatic out_t e_la_gap(logic [7:0] t);
        return expo(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, t, 0);
    endfunction
    function automatic out_t e_rdy(logic [7:0] t);
        return expo(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, t, 0);
    endfunction
    function automatic out_t e_wait(logic [7:0] t, logic alld);
        return expo(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, t, alld);
    endfunction

    function automatic vec_t mkv(string nm, logic r, logic s, logic bv, logic [15:0] bi,
                                 logic av, logic [15:0] ai, logic td, out_t e);
        vec_t v;
        v.name = nm; v.rst_n = r; v.st = s; v.bv = bv; v.bi = bi;
        v.av = av; v.ai = ai; v.td = td; v.exp = e;
        return v;
    endfunction

    task automatic apply(logic r, logic s, logic bv, logic [15:0] bi,
                         logic av, logic [15:0] ai, logic td);
        arst_n_in = r; start = s; b_valid = bv; b_input = bi;
        a_valid = av; a_input = ai; tile_done = td;
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    initial begin
        int seen_at;
        int nb_w;
        int na_w;

        // Main job: reset, weight load with a-port noise, gappy activations, two tiles.
        vq.push_back(mkv("rst_over_start", 0, 1, 1, 16'h11, 1, 16'h55, 0, '0));
        vq.push_back(mkv("idle",           1, 0, 0, 16'h00, 0, 16'h00, 0, '0));
        vq.push_back(mkv("idle_start",     1, 1, 1, 16'h11, 0, 16'h00, 0, '0));
        vq.push_back(mkv("lb0",            1, 0, 1, 16'h11, 1, 16'h55, 0, e_lb(0, 16'h11)));
        vq.push_back(mkv("lb1",            1, 0, 1, 16'h22, 1, 16'h55, 0, e_lb(1, 16'h22)));
        vq.push_back(mkv("lb2",            1, 0, 1, 16'h33, 1, 16'h55, 0, e_lb(2, 16'h33)));
        vq.push_back(mkv("la0_td_ignored", 1, 0, 1, 16'h44, 1, 16'hA0, 1, e_la(0, 16'hA0, 0)));
        vq.push_back(mkv("la_gap_start",   1, 1, 0, 16'h00, 0, 16'hA1, 0, e_la_gap(0)));
        vq.push_back(mkv("la1",            1, 0, 1, 16'h44, 1, 16'hA1, 0, e_la(1, 16'hA1, 0)));
        vq.push_back(mkv("la_gap_td",      1, 0, 0, 16'h00, 0, 16'hA2, 1, e_la_gap(0)));
        vq.push_back(mkv("la2",            1, 0, 0, 16'h00, 1, 16'hA2, 0, e_la(2, 16'hA2, 0)));
        vq.push_back(mkv("la_gap3",        1, 0, 0, 16'h00, 0, 16'hA3, 0, e_la_gap(0)));
        vq.push_back(mkv("la3",            1, 0, 0, 16'h00, 1, 16'hA3, 0, e_la(3, 16'hA3, 0)));
        vq.push_back(mkv("ready_t0",       1, 0, 0, 16'h00, 0, 16'h00, 0, e_rdy(0)));
        vq.push_back(mkv("wait_start_ign", 1, 1, 0, 16'h00, 0, 16'h00, 0, e_wait(0, 0)));
        vq.push_back(mkv("wait_done_t0",   1, 0, 0, 16'h00, 0, 16'h00, 1, e_wait(0, 0)));
        vq.push_back(mkv("t1_la0_no_b",    1, 0, 1, 16'h66, 1, 16'hB0, 0, e_la(0, 16'hB0, 1)));
        vq.push_back(mkv("t1_la1",         1, 0, 1, 16'h66, 1, 16'hB1, 0, e_la(1, 16'hB1, 1)));
        vq.push_back(mkv("t1_la2",         1, 0, 0, 16'h00, 1, 16'hB2, 0, e_la(2, 16'hB2, 1)));
        vq.push_back(mkv("t1_la3",         1, 0, 0, 16'h00, 1, 16'hB3, 0, e_la(3, 16'hB3, 1)));
        vq.push_back(mkv("ready_t1",       1, 0, 0, 16'h00, 0, 16'h00, 0, e_rdy(1)));
        vq.push_back(mkv("wait_t1",        1, 0, 0, 16'h00, 0, 16'h00, 0, e_wait(1, 0)));
        vq.push_back(mkv("all_done",       1, 0, 0, 16'h00, 0, 16'h00, 1, e_wait(1, 1)));
        vq.push_back(mkv("idle_after",     1, 0, 0, 16'h00, 0, 16'h00, 0, '0));

        // Two reset edges so the table starts from a known state.
        apply(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i].rst_n, vq[i].st, vq[i].bv, vq[i].bi, vq[i].av, vq[i].ai, vq[i].td);
            chk(vq[i].name, 64'(w_out), 64'(vq[i].exp));
            tick();
        end

        // Reset after two of four activation words aborts the load.
        apply(1, 1, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 1, 16'h0C0 + 16'(i), 0, 0, 0); tick();
        end
        for (int i = 0; i < 2; i++) begin
            apply(1, 0, 0, 0, 1, 16'hD0 + 16'(i), 0);
            chk("mid_a_write", 64'(a_mem_we), 64'd1);
            tick();
        end
        apply(0, 0, 0, 0, 1, 16'hD2, 0);
        chk("rst_cycle_outs", 64'(w_out), 64'd0);
        tick();
        apply(1, 0, 1, 16'h99, 1, 16'hD3, 0);
        chk("post_rst_idle", 64'(w_out), 64'd0);
        tick();
        apply(1, 1, 0, 0, 0, 0, 0); tick();
        apply(1, 0, 1, 16'h77, 0, 0, 0);
        chk("reload_b_we", 64'(b_mem_we), 64'd1);
        chk("reload_b_addr", 64'(b_mem_addr), 64'd0);
        chk("reload_b_data", 64'(b_mem_wdata), 64'h77);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0); tick();

        // Everything held high: full job, then start relaunches after one IDLE cycle.
        seen_at = -1; nb_w = 0; na_w = 0;
        for (int c = 0; c < 40; c++) begin
            apply(1, 1, 1, 16'h10, 1, 16'h20, 1);
            if (b_mem_we) nb_w++;
            if (a_mem_we) na_w++;
            if (all_done) begin
                seen_at = c;
                tick();
                break;
            end
            tick();
        end
        chk("all_done_cycle", 64'(seen_at), 64'd15);
        chk("held_b_writes", 64'(nb_w), 64'd3);
        chk("held_a_writes", 64'(na_w), 64'd8);
        apply(1, 1, 1, 16'h10, 1, 16'h20, 1);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_no_write", 64'(b_mem_we), 64'd0);
        tick();
        apply(1, 1, 1, 16'h10, 1, 16'h20, 1);
        chk("relaunch_b_ready", 64'(b_ready), 64'd1);
        chk("relaunch_b_addr", 64'(b_mem_addr), 64'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/operand_load_scheduler.md
OPERAND_LOAD_SCHEDULER -- requirements
Module: operand_load_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of one operand word.
REQ-002 Parameter LOG2_OF_MEM_HEIGHT, default 20: operand memory address width.
REQ-003 Parameter B_WORDS, default 36864: weight words per job (KERNEL_SIZE^2 x INPUT_NB_CHANNELS x OUTPUT_NB_CHANNELS).
REQ-004 Parameter A_WORDS, default 4096: activation words per tile.
REQ-005 Parameter NB_TILES, default 2: tiles per job.
REQ-006 The block SHALL have one clock; reset is synchronous and active-low.
REQ-007 clk  in  1  clock; all state updates on its rising edge.
REQ-008 arst_n_in  in  1  synchronous active-low reset.
REQ-009 start  in  1  job launch request.
REQ-010 busy  out  1  high whenever the state is not IDLE.
REQ-011 b_input / b_valid / b_ready  in/in/out  DATA_WIDTH/1/1  weight stream handshake.
REQ-012 a_input / a_valid / a_ready  in/in/out  DATA_WIDTH/1/1  activation stream handshake.
REQ-013 b_mem_we / b_mem_addr / b_mem_wdata  out/out/out  1/LOG2_OF_MEM_HEIGHT/DATA_WIDTH  weight memory write port.
REQ-014 a_mem_we / a_mem_addr / a_mem_wdata  out/out/out  1/LOG2_OF_MEM_HEIGHT/DATA_WIDTH  activation memory write port.
REQ-015 data_ready  out  1  one-cycle pulse: tile operands resident; drives the controller FSM data_ready input.
REQ-016 tile_done  in  1  controller reports the current tile is fully computed.
REQ-017 tile_idx  out  8  index of the tile currently loaded or computing.
REQ-018 all_done  out  1  one-cycle pulse when the last tile completes.

Function
REQ-019 States SHALL be IDLE, LOAD_B, LOAD_A, READY, WAIT_DONE.
REQ-020 IDLE: a_ready=b_ready=0; start=1 -> LOAD_B; b_cnt, a_cnt, tile_idx cleared to 0.
REQ-021 LOAD_B: b_ready=1, a_ready=0; handshake (b_valid&&b_ready) -> b_mem_we=1 in the same cycle, b_mem_addr=b_cnt, b_mem_wdata=b_input, b_cnt+1.
REQ-022 Handshake with b_cnt==B_WORDS-1 -> b_cnt wraps to 0, next state LOAD_A.
REQ-023 LOAD_A: a_ready=1, b_ready=0; same write rule on the a-port using a_cnt; handshake with a_cnt==A_WORDS-1 -> a_cnt=0, next state READY.
REQ-024 READY: data_ready=1 for exactly one cycle -> WAIT_DONE.
REQ-025 WAIT_DONE: tile_done=1 and tile_idx<NB_TILES-1 -> tile_idx+1, next state LOAD_A; weights are not reloaded.
REQ-026 WAIT_DONE: tile_done=1 and tile_idx==NB_TILES-1 -> all_done=1 for one cycle, next state IDLE.
REQ-027 Memory write enables SHALL be low in every cycle without a handshake; valid without ready is never written.
REQ-028 start is ignored outside IDLE; tile_done is ignored outside WAIT_DONE.
REQ-029 start held high through the all_done cycle SHALL relaunch the job one cycle after returning to IDLE.
REQ-030 Internal counters SHALL be 32 bit; addresses are the low LOG2_OF_MEM_HEIGHT bits.
REQ-031 Elaboration SHALL fail if A_WORDS or B_WORDS > 2^LOG2_OF_MEM_HEIGHT, or if NB_TILES is 0 or > 256.

Reset
REQ-032 arst_n_in=0 at a clock edge SHALL force IDLE; counters and tile_idx to 0.
REQ-033 All outputs SHALL be 0 in reset and in IDLE, including busy, ready, write enables, data_ready and all_done.
REQ-034 Reset mid-load SHALL abort with no further memory writes; reset overrides start in the same cycle.

Structure
REQ-035 Package operand_load_pkg SHALL hold the state enum load_state_t and the default parameter constants.
REQ-036 One sub-module load_counter (32-bit, synchronous clear, enable, wrap at a parameterised limit, last flag) SHALL implement b_cnt and a_cnt.

Verification (B_WORDS=3, A_WORDS=4, NB_TILES=2)
REQ-037 start pulse, b_valid continuous with words 0x11,0x22,0x33 -> b_mem writes at addr 0,1,2 on consecutive cycles; b_ready drops after the third word.
REQ-038 Activation words 0xA0..0xA3 with a_valid toggled 1,0,1,0… -> exactly 4 writes at addr 0..3; data_ready pulses once, one cycle after the last write.
REQ-039 First tile_done -> tile_idx=1, LOAD_A with no b_ready; after 4 more a-words and the second tile_done -> all_done pulse, busy=0 the next cycle.
REQ-040 a_valid=1 during LOAD_B and b_valid=1 during LOAD_A -> no a-port or b-port writes, respectively.
REQ-041 Reset asserted after 2 of 4 a-words -> IDLE next cycle, no writes, all outputs 0; a new start reloads weights from addr 0.
REQ-042 tile_done pulsed during LOAD_A, and start pulsed during WAIT_DONE -> both ignored; tile_idx and state unchanged.
